// File: rtl/neural_clk_gen_if.sv
// Bus bundle for the emulation clock generator.
// The master side programs the neuron_clk half-period and observes the
// derived clocks and the neuron-slot counter. The slave side is the generator.
interface neural_clk_gen_if #(
    parameter int NN = 8
);
    logic [17:0]   half_cnt;
    logic          clk_out1;
    logic          clk_out2;
    logic          clk_out3;
    logic [NN+2:0] int_neuron_cnt_out;

    modport master (
        output half_cnt,
        input  clk_out1,
        input  clk_out2,
        input  clk_out3,
        input  int_neuron_cnt_out
    );

    modport slave (
        input  half_cnt,
        output clk_out1,
        output clk_out2,
        output clk_out3,
        output int_neuron_cnt_out
    );
endinterface

// File: rtl/neural_clk_gen.sv
// Emulation clock tree generator.
// Divides rawclk into neuron_clk (clk_out1), then derives sim_clk (clk_out2)
// and spindle_clk (clk_out3) from bits of the free-running neuron-slot counter.
// Every output is a plain register in the rawclk domain, so all derived edges
// land on the same rawclk edge and no internal logic runs on a derived clock.
// NN must be at least 2 so that the spindle tap NN-2 exists.
module neural_clk_gen #(
    parameter int NN = 8
) (
    input  logic             rawclk,
    input  logic             reset,
    neural_clk_gen_if.slave  bus
);

    localparam int CW = NN + 3;

    logic [17:0]   div_cnt;
    logic          neuron_q;
    logic          sim_q;
    logic          spindle_q;
    logic [CW-1:0] counter_q;
    logic [CW-1:0] next_counter;
    logic          half_done;
    logic          neuron_rise;

    // A half-period ends as soon as the count reaches or passes the live
    // half_cnt, so lowering half_cnt mid-period ends it on the next edge.
    assign half_done    = (div_cnt >= bus.half_cnt);
    assign neuron_rise  = half_done && !neuron_q;
    assign next_counter = counter_q + CW'(1);

    // Half-period divider: count rawclk edges and toggle neuron_clk at the end of each half.
    always_ff @(posedge rawclk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            neuron_q <= 1'b0;
        end else if (half_done) begin
            div_cnt  <= '0;
            neuron_q <= ~neuron_q;
        end else begin
            div_cnt  <= div_cnt + 18'd1;
        end
    end

    // Slot counter and its clock taps advance together on the edge where neuron_clk rises.
    always_ff @(posedge rawclk or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            sim_q     <= 1'b0;
            spindle_q <= 1'b0;
        end else if (neuron_rise) begin
            counter_q <= next_counter;
            sim_q     <= next_counter[NN];
            spindle_q <= next_counter[NN-2];
        end
    end

    assign bus.clk_out1           = neuron_q;
    assign bus.clk_out2           = sim_q;
    assign bus.clk_out3           = spindle_q;
    assign bus.int_neuron_cnt_out = counter_q;

endmodule

// File: tb/tb_neural_clk_gen.sv
// Self-checking bench for neural_clk_gen.
// The reference model keeps an unbounded count of neuron_clk rising edges and
// derives every expected output from it arithmetically.
module tb_neural_clk_gen;

    localparam int NN = 8;
    localparam int CW = NN + 3;

    logic rawclk = 1'b0;
    logic reset  = 1'b1;

    neural_clk_gen_if #(.NN(NN)) bus ();

    neural_clk_gen #(.NN(NN)) dut (
        .rawclk (rawclk),
        .reset  (reset),
        .bus    (bus)
    );

    // 100 MHz-style free-running bench clock, 10 time units per rawclk period.
    always #5 rawclk = ~rawclk;

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since the last neuron_clk toggle,
    // total toggles and total rising edges since reset.
    int m_since;
    int m_toggles;
    int m_rises;

    task automatic modelReset();
        m_since   = 0;
        m_toggles = 0;
        m_rises   = 0;
    endtask

    task automatic modelEdge();
        if (m_since >= int'(bus.half_cnt)) begin
            m_since = 0;
            m_toggles++;
            if (m_toggles % 2 == 1) m_rises++;
        end else begin
            m_since++;
        end
    endtask

    function automatic logic [CW+2:0] expected();
        logic          lvl;
        logic          sim;
        logic          spin;
        logic [CW-1:0] cnt;
        lvl  = logic'(m_toggles % 2);
        sim  = logic'((m_rises >> NN) & 1);
        spin = logic'((m_rises >> (NN - 2)) & 1);
        cnt  = CW'(m_rises % (1 << CW));
        return {lvl, sim, spin, cnt};
    endfunction

    function automatic logic [CW+2:0] observed();
        return {bus.clk_out1, bus.clk_out2, bus.clk_out3, bus.int_neuron_cnt_out};
    endfunction

    task automatic checkOutput(input string tag, input logic [CW+2:0] obs, input logic [CW+2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rawclk cycles, stepping the model at each edge and comparing at the following negedge.
    task automatic applyStimulus(input int n, input string tag);
        repeat (n) begin
            @(posedge rawclk);
            if (!reset) modelEdge();
            @(negedge rawclk);
            checkOutput(tag, observed(), expected());
        end
    endtask

    // Count cycles for which clk_out1 stays at lvl, bounded so a stuck clock cannot hang the run.
    task automatic measurePhase(input logic lvl, input string tag, output int n);
        n = 0;
        while (bus.clk_out1 === lvl && n < 2000) begin
            applyStimulus(1, tag);
            n++;
        end
    endtask

    // Assert reset for 14 cycles with half_cnt=197, release it, and check the first neuron_clk rise.
    task automatic resetSequence(input string tag);
        int n;
        bus.half_cnt = 18'd197;
        reset = 1'b1;
        modelReset();
        applyStimulus(14, {tag, "_hold"});
        checkValue({tag, "_hold_outputs"}, int'(observed()), 0);
        reset = 1'b0;
        measurePhase(1'b0, {tag, "_first_low"}, n);
        checkValue({tag, "_first_rise_delay"}, n, 198);
        checkValue({tag, "_first_rise_counter"}, int'(bus.int_neuron_cnt_out), 1);
    endtask

    initial begin
        int  n;
        bit  wrapped;
        logic          p1, p2, p3;
        logic [CW-1:0] pcnt;

        bus.half_cnt = 18'd197;
        modelReset();
        @(negedge rawclk);

        // Reset behaviour and first rise after release
        resetSequence("t1");

        // Steady half_cnt=197: both phases 198 cycles
        measurePhase(1'b1, "t2_high", n);
        checkValue("t2_high_len", n, 198);
        measurePhase(1'b0, "t2_low", n);
        checkValue("t2_low_len", n, 198);

        // Lower half_cnt while div_cnt sits at 100: toggle on the very next edge
        measurePhase(1'b1, "t4_high", n);
        applyStimulus(100, "t4_count");
        bus.half_cnt = 18'd10;
        applyStimulus(1, "t4_cut");
        checkValue("t4_cut_level", int'(bus.clk_out1), 1);
        measurePhase(1'b1, "t4_h11", n);
        checkValue("t4_half_high", n, 11);
        measurePhase(1'b0, "t4_l11", n);
        checkValue("t4_half_low", n, 11);

        // half_cnt=0: rawclk/2, counter wrap, and derived-clock alignment
        bus.half_cnt = 18'd0;
        wrapped = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            p1 = bus.clk_out1;
            p2 = bus.clk_out2;
            p3 = bus.clk_out3;
            pcnt = bus.int_neuron_cnt_out;
            applyStimulus(1, "t3_fast");
            if (pcnt == CW'(2047) && bus.int_neuron_cnt_out == '0) wrapped = 1'b1;
            if (bus.clk_out2 !== p2 || bus.clk_out3 !== p3)
                checkValue("t6_edge_aligned", int'({p1, bus.clk_out1}), 1);
            if (i % 64 == 0) begin
                checkValue("t6_spindle_tap", int'(bus.clk_out3), int'(bus.int_neuron_cnt_out[NN-2]));
                checkValue("t6_sim_tap", int'(bus.clk_out2), int'(bus.int_neuron_cnt_out[NN]));
            end
        end
        checkValue("t3_wrap_seen", int'(wrapped), 1);

        // Asynchronous reset in the middle of a sim_clk high phase
        n = 0;
        while (bus.clk_out2 !== 1'b1 && n < 3000) begin
            applyStimulus(1, "t5_seek");
            n++;
        end
        checkValue("t5_sim_high_reached", int'(bus.clk_out2), 1);
        applyStimulus(7, "t5_in_high");
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkValue("t5_async_clear", int'(observed()), 0);
        @(negedge rawclk);
        resetSequence("t5");

        // Randomized half_cnt changes with occasional asynchronous resets
        for (int seg = 0; seg < 40; seg++) begin
            bus.half_cnt = 18'($urandom_range(0, 30));
            applyStimulus(int'($urandom_range(1, 150)), "rand");
            if ($urandom_range(0, 9) == 0) begin
                #($urandom_range(1, 4));
                reset = 1'b1;
                #1;
                modelReset();
                checkValue("rand_async_clear", int'(observed()), 0);
                @(negedge rawclk);
                applyStimulus(3, "rand_hold");
                reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
